// File: rtl/l1d_package.sv
// Shared L1D types: data-RAM request payload, request-source enum and the
// evict-buffer depth used by both the arbiter and the data RAM block.
package l1d_package;

    localparam int L1D_EVB_DEPTH = 4;

    typedef struct packed {
        logic       wr_en;
        logic [1:0] way;
        logic [5:0] index;
        logic [7:0] data;
    } pack_l1d_data_ram_req;

    typedef enum logic [1:0] {
        SRC_RF,
        SRC_EV,
        SRC_HIT
    } l1d_dram_src_e;

endpackage

// File: rtl/l1d_data_ram_req_arb_if.sv
// Request-side bundle of the data-RAM arbiter: three source handshakes,
// the evict-buffer release pulse and the registered data-RAM request.
interface l1d_data_ram_req_arb_if
    import l1d_package::*;
#(
    parameter int EVB_DEPTH = L1D_EVB_DEPTH
) ();

    logic                             rf_req_vld;
    logic                             rf_req_rdy;
    pack_l1d_data_ram_req             rf_req_pld;
    logic                             ev_req_vld;
    logic                             ev_req_rdy;
    pack_l1d_data_ram_req             ev_req_pld;
    logic                             hit_req_vld;
    logic                             hit_req_rdy;
    pack_l1d_data_ram_req             hit_req_pld;
    logic                             evb_release;
    logic                             data_ram_req_vld;
    logic                             data_ram_req_rdy;
    pack_l1d_data_ram_req             data_ram_req_pld;
    logic                             evict_req_id;
    logic [$clog2(EVB_DEPTH+1)-1:0]   evb_credit;

    modport master (
        input  rf_req_vld, rf_req_pld,
        input  ev_req_vld, ev_req_pld,
        input  hit_req_vld, hit_req_pld,
        input  evb_release, data_ram_req_rdy,
        output rf_req_rdy, ev_req_rdy, hit_req_rdy,
        output data_ram_req_vld, data_ram_req_pld, evict_req_id, evb_credit
    );

    modport slave (
        output rf_req_vld, rf_req_pld,
        output ev_req_vld, ev_req_pld,
        output hit_req_vld, hit_req_pld,
        output evb_release, data_ram_req_rdy,
        input  rf_req_rdy, ev_req_rdy, hit_req_rdy,
        input  data_ram_req_vld, data_ram_req_pld, evict_req_id, evb_credit
    );

endinterface

// File: rtl/l1d_data_ram_req_arb_credit_cnt.sv
// l1d_evb_credit_cnt: free evict-buffer entry counter, starts full,
// saturates at DEPTH and flags a release that would exceed it.
module l1d_evb_credit_cnt #(
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dec,
    input  logic          inc,
    output logic [CW-1:0] cnt
);

    // Simultaneous take and release cancel; a release with all entries free is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= CW'(DEPTH);
        end else if (dec && !inc) begin
            cnt <= cnt - CW'(1);
        end else if (inc && !dec && (cnt != CW'(DEPTH))) begin
            cnt <= cnt + CW'(1);
        end
    end

    evb_overflow_chk: assert property (@(posedge clk) disable iff (rst)
        !(inc && !dec && (cnt == CW'(DEPTH))))
        else $warning("evb_release received with every evict-buffer entry already free");

endmodule

// File: rtl/l1d_data_ram_req_arb.sv
// Fixed-priority (rf > ev > hit) arbiter feeding the data RAM through one output register.
// Define L1D_ARB_STARVE_GUARD_EN to let a long-starved hit request jump to the front.
module l1d_data_ram_req_arb
    import l1d_package::*;
#(
    parameter int EVB_DEPTH    = L1D_EVB_DEPTH,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    l1d_data_ram_req_arb_if.master bus
);

    localparam int CREDIT_W = $clog2(EVB_DEPTH+1);

    if ((STARVE_LIMIT < 1) || (EVB_DEPTH < 1)) begin : g_bad_params
        $error("l1d_data_ram_req_arb: STARVE_LIMIT and EVB_DEPTH must be at least 1");
    end

    logic                 load_en;
    logic                 ev_elig;
    logic                 force_hit;
    logic                 any_grant;
    l1d_dram_src_e        grant_src;
    pack_l1d_data_ram_req sel_pld;
    pack_l1d_data_ram_req out_pld;
    logic                 out_vld;
    logic                 out_evict;
    logic [CREDIT_W-1:0]  evb_credit;

    assign load_en = !out_vld || bus.data_ram_req_rdy;
    assign ev_elig = bus.ev_req_vld && (evb_credit != '0);

    // One winner per loadable cycle; nothing is granted while reset is held.
    always_comb begin
        any_grant = 1'b0;
        grant_src = SRC_RF;
        if (!rst && load_en) begin
            if (force_hit && bus.hit_req_vld) begin
                any_grant = 1'b1;
                grant_src = SRC_HIT;
            end else if (bus.rf_req_vld) begin
                any_grant = 1'b1;
                grant_src = SRC_RF;
            end else if (ev_elig) begin
                any_grant = 1'b1;
                grant_src = SRC_EV;
            end else if (bus.hit_req_vld) begin
                any_grant = 1'b1;
                grant_src = SRC_HIT;
            end
        end
    end

    always_comb begin
        case (grant_src)
            SRC_EV:  sel_pld = bus.ev_req_pld;
            SRC_HIT: sel_pld = bus.hit_req_pld;
            default: sel_pld = bus.rf_req_pld;
        endcase
    end

    assign bus.rf_req_rdy  = any_grant && (grant_src == SRC_RF);
    assign bus.ev_req_rdy  = any_grant && (grant_src == SRC_EV);
    assign bus.hit_req_rdy = any_grant && (grant_src == SRC_HIT);

    // Payload only changes on an actual grant so a drained slot keeps its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld   <= 1'b0;
            out_pld   <= '0;
            out_evict <= 1'b0;
        end else if (load_en) begin
            out_vld <= any_grant;
            if (any_grant) begin
                out_pld   <= sel_pld;
                out_evict <= (grant_src == SRC_EV);
            end
        end
    end

    assign bus.data_ram_req_vld = out_vld;
    assign bus.data_ram_req_pld = out_pld;
    assign bus.evict_req_id     = out_evict;
    assign bus.evb_credit       = evb_credit;

    l1d_evb_credit_cnt #(
        .DEPTH (EVB_DEPTH)
    ) u_credit (
        .clk (clk),
        .rst (rst),
        .dec (bus.ev_req_rdy),
        .inc (bus.evb_release),
        .cnt (evb_credit)
    );

`ifdef L1D_ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT+1);

    logic [STARVE_W-1:0] starve_cnt;

    assign force_hit = (starve_cnt == STARVE_W'(STARVE_LIMIT));

    // Counts loadable cycles a waiting hit request lost; never passes the limit
    // because reaching it forces the very next grant to hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!bus.hit_req_vld || bus.hit_req_rdy) begin
            starve_cnt <= '0;
        end else if (load_en) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end
`else
    assign force_hit = 1'b0;
`endif

endmodule
